// File: rtl/pipe_pkg.sv
// ---- pipe_pkg : shared ALU opcodes, ID/EX control record and bubble constant (rev 1.0) ----
`default_nettype none

package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int ALU_W  = 4;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_NOR = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SRL = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SRA = 4'b1001;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic [ALU_W-1:0] ctrl_alu;
    logic             alu_src_imm;
    logic             shift_src;
  } idex_ctrl_t;

  // A bubble has no side effects: it neither writes, loads nor stores.
  localparam idex_ctrl_t CTRL_BUBBLE = '{
    valid:       1'b0,
    reg_write:   1'b0,
    mem_read:    1'b0,
    mem_write:   1'b0,
    mem_to_reg:  1'b0,
    ctrl_alu:    ALU_ADD,
    alu_src_imm: 1'b0,
    shift_src:   1'b0
  };

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_unit.sv
// ---- fwd_unit : selects the newest in-flight value for one source register (rev 1.0) ----
`default_nettype none

module fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exm_reg_write_i,
  input  logic [REG_W-1:0]  exm_rd_i,
  input  logic [DATA_W-1:0] exm_result_i,
  input  logic              mwb_reg_write_i,
  input  logic [REG_W-1:0]  mwb_rd_i,
  input  logic [DATA_W-1:0] mwb_result_i,
  output logic [DATA_W-1:0] fwd_data_o
);

  logic exm_hit;
  logic mwb_hit;

  // $zero is hard-wired, so a writer targeting it must never be forwarded.
  assign exm_hit = exm_reg_write_i && (exm_rd_i != '0) && (exm_rd_i == idx_i);
  assign mwb_hit = mwb_reg_write_i && (mwb_rd_i != '0) && (mwb_rd_i == idx_i);

  always_comb begin
    fwd_data_o = reg_data_i;
    if (exm_hit) begin
      fwd_data_o = exm_result_i;
    end else if (mwb_hit) begin
      fwd_data_o = mwb_result_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ---- id_ex_stage : ID/EX register with bubble insertion, load-use detect and forwarding (rev 1.0) ----
`default_nettype none

module id_ex_stage
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [3:0]  id_ctrl_alu,
  input  logic        id_alu_src_imm,
  input  logic        id_shift_src,
  input  logic        id_uses_rt,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        exm_reg_write,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mwb_reg_write,
  input  logic [4:0]  mwb_rd,
  input  logic [31:0] mwb_result,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        load_use,
  output logic [15:0] bubble_count
);

  idex_ctrl_t        ctrl_q,         ctrl_d;
  logic [REG_W-1:0]  rs_q,           rs_d;
  logic [REG_W-1:0]  rt_q,           rt_d;
  logic [REG_W-1:0]  rd_q,           rd_d;
  logic [DATA_W-1:0] rs_data_q,      rs_data_d;
  logic [DATA_W-1:0] rt_data_q,      rt_data_d;
  logic [DATA_W-1:0] imm_q,          imm_d;
  logic [REG_W-1:0]  shamt_q,        shamt_d;
  logic [15:0]       bubble_count_q, bubble_count_d;

  idex_ctrl_t        id_ctrl;
  logic              rs_match;
  logic              rt_match;
  logic              bubble_write;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  always_comb begin
    id_ctrl             = CTRL_BUBBLE;
    id_ctrl.valid       = id_valid;
    id_ctrl.reg_write   = id_reg_write;
    id_ctrl.mem_read    = id_mem_read;
    id_ctrl.mem_write   = id_mem_write;
    id_ctrl.mem_to_reg  = id_mem_to_reg;
    id_ctrl.ctrl_alu    = id_ctrl_alu;
    id_ctrl.alu_src_imm = id_alu_src_imm;
    id_ctrl.shift_src   = id_shift_src;
  end

  // A load in EX cannot forward in time; the dependent instruction in ID must wait one cycle.
  assign rs_match = (id_rs == rd_q);
  assign rt_match = id_uses_rt && (id_rt == rd_q);
  assign load_use = !stall && ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) &&
                    id_valid && (rs_match || rt_match);

  assign bubble_write = flush || load_use;

  always_comb begin
    ctrl_d         = ctrl_q;
    rs_d           = rs_q;
    rt_d           = rt_q;
    rd_d           = rd_q;
    rs_data_d      = rs_data_q;
    rt_data_d      = rt_data_q;
    imm_d          = imm_q;
    shamt_d        = shamt_q;
    bubble_count_d = bubble_count_q;

    if (bubble_write) begin
      ctrl_d         = CTRL_BUBBLE;
      rs_d           = '0;
      rt_d           = '0;
      rd_d           = '0;
      rs_data_d      = '0;
      rt_data_d      = '0;
      imm_d          = '0;
      shamt_d        = '0;
      bubble_count_d = sat_inc16(bubble_count_q);
    end else if (!stall) begin
      ctrl_d    = id_ctrl;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      shamt_d   = id_shamt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q         <= CTRL_BUBBLE;
      rs_q           <= '0;
      rt_q           <= '0;
      rd_q           <= '0;
      rs_data_q      <= '0;
      rt_data_q      <= '0;
      imm_q          <= '0;
      shamt_q        <= '0;
      bubble_count_q <= '0;
    end else begin
      ctrl_q         <= ctrl_d;
      rs_q           <= rs_d;
      rt_q           <= rt_d;
      rd_q           <= rd_d;
      rs_data_q      <= rs_data_d;
      rt_data_q      <= rt_data_d;
      imm_q          <= imm_d;
      shamt_q        <= shamt_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  fwd_unit u_fwd_rs (
    .idx_i           (rs_q),
    .reg_data_i      (rs_data_q),
    .exm_reg_write_i (exm_reg_write),
    .exm_rd_i        (exm_rd),
    .exm_result_i    (exm_result),
    .mwb_reg_write_i (mwb_reg_write),
    .mwb_rd_i        (mwb_rd),
    .mwb_result_i    (mwb_result),
    .fwd_data_o      (fwd_rs)
  );

  fwd_unit u_fwd_rt (
    .idx_i           (rt_q),
    .reg_data_i      (rt_data_q),
    .exm_reg_write_i (exm_reg_write),
    .exm_rd_i        (exm_rd),
    .exm_result_i    (exm_result),
    .mwb_reg_write_i (mwb_reg_write),
    .mwb_rd_i        (mwb_rd),
    .mwb_result_i    (mwb_result),
    .fwd_data_o      (fwd_rt)
  );

  assign alu_in1       = ctrl_q.shift_src ? {27'b0, shamt_q} : fwd_rs;
  assign alu_in2       = ctrl_q.alu_src_imm ? imm_q : fwd_rt;
  assign alu_ctrl      = ctrl_q.ctrl_alu;
  assign ex_store_data = fwd_rt;
  assign ex_rd         = rd_q;
  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign bubble_count  = bubble_count_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ---- tb_id_ex_stage : directed self-checking bench for id_ex_stage (rev 1.0) ----
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_ctrl_alu;
  logic        id_alu_src_imm, id_shift_src, id_uses_rt;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        load_use;
  logic [15:0] bubble_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_ctrl_alu(id_ctrl_alu),
    .id_alu_src_imm(id_alu_src_imm), .id_shift_src(id_shift_src),
    .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .load_use(load_use), .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_ctrl_alu = 0;
    id_alu_src_imm = 0; id_shift_src = 0; id_uses_rt = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
  endtask

  task automatic clear_fwd();
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    clear_id();
    clear_fwd();
    #1;
    chk("reset_alu_in1", alu_in1, 32'h0);
    chk("reset_ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("reset_bubble_count", {16'b0, bubble_count}, 32'h0);
    step();
    rst = 0;

    // Plain capture
    id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 3; id_uses_rt = 1; id_reg_write = 1;
    id_rs_data = 32'd5; id_rt_data = 32'd7; id_ctrl_alu = 4'b0000;
    step();
    chk("cap_alu_in1", alu_in1, 32'd5);
    chk("cap_alu_in2", alu_in2, 32'd7);
    chk("cap_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    chk("cap_ex_valid", {31'b0, ex_valid}, 32'h1);
    chk("cap_ex_rd", {27'b0, ex_rd}, 32'd3);
    chk("cap_store_data", ex_store_data, 32'd7);

    // Forwarding priority on rs=3
    id_rs = 3; id_rs_data = 32'h11;
    step();
    exm_reg_write = 1; exm_rd = 3; exm_result = 32'hAAAA;
    mwb_reg_write = 1; mwb_rd = 3; mwb_result = 32'hBBBB;
    #1 chk("fwd_both_exm_wins", alu_in1, 32'hAAAA);
    exm_rd = 0;
    #1 chk("fwd_exm_rd0_mwb", alu_in1, 32'hBBBB);
    exm_rd = 3; exm_reg_write = 0;
    #1 chk("fwd_exm_nowr_mwb", alu_in1, 32'hBBBB);
    mwb_reg_write = 0;
    #1 chk("fwd_none_regfile", alu_in1, 32'h11);
    clear_fwd();

    // Register 0 never forwards
    id_rs = 0; id_rs_data = 32'h22;
    step();
    exm_reg_write = 1; exm_rd = 0; exm_result = 32'hDEAD;
    mwb_reg_write = 1; mwb_rd = 0; mwb_result = 32'hBEEF;
    #1 chk("fwd_r0_blocked", alu_in1, 32'h22);
    clear_fwd();

    // Load-use: lw r8 into EX, then add r10 = r8 + r9 in ID
    clear_id();
    id_valid = 1; id_rd = 8; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
    step();
    clear_id();
    id_valid = 1; id_rs = 8; id_rt = 9; id_rd = 10; id_uses_rt = 1; id_reg_write = 1;
    id_rs_data = 32'h999; id_rt_data = 32'h4;
    #1 chk("lu_detect", {31'b0, load_use}, 32'h1);
    stall = 1;
    #1 chk("lu_masked_by_stall", {31'b0, load_use}, 32'h0);
    stall = 0;
    step();
    chk("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
    chk("lu_bubble_count", {16'b0, bubble_count}, 32'h1);
    chk("lu_deassert", {31'b0, load_use}, 32'h0);
    mwb_reg_write = 1; mwb_rd = 8; mwb_result = 32'h1234;
    step();
    chk("lu_add_valid", {31'b0, ex_valid}, 32'h1);
    chk("lu_add_fwd", alu_in1, 32'h1234);
    chk("lu_add_rd", {27'b0, ex_rd}, 32'd10);
    clear_fwd();

    // Shift amount and immediate operand selection
    clear_id();
    id_valid = 1; id_shift_src = 1; id_shamt = 5'd17; id_alu_src_imm = 1;
    id_imm = 32'hFFFF_FFF0; id_ctrl_alu = 4'b0111; id_rs = 4; id_rs_data = 32'h77;
    id_rt = 2; id_rt_data = 32'h55;
    step();
    chk("shimm_alu_in1", alu_in1, 32'd17);
    chk("shimm_alu_in2", alu_in2, 32'hFFFF_FFF0);
    chk("shimm_alu_ctrl", {28'b0, alu_ctrl}, 32'h7);
    chk("shimm_store", ex_store_data, 32'h55);

    // Stall holds for three cycles despite new ID contents
    stall = 1;
    clear_id();
    id_valid = 1; id_rs_data = 32'h3; id_ctrl_alu = 4'b0001; id_rd = 5'd20;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_alu_in1", alu_in1, 32'd17);
      chk("stall_alu_ctrl", {28'b0, alu_ctrl}, 32'h7);
    end

    // Flush beats stall
    flush = 1;
    step();
    chk("flst_valid", {31'b0, ex_valid}, 32'h0);
    chk("flst_alu_in2", alu_in2, 32'h0);
    chk("flst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    chk("flst_bubble_count", {16'b0, bubble_count}, 32'h2);
    flush = 0; stall = 0;

    // Asynchronous reset mid-cycle
    step();
    chk("pre_rst_valid", {31'b0, ex_valid}, 32'h1);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("async_rst_rd", {27'b0, ex_rd}, 32'h0);
    chk("async_rst_count", {16'b0, bubble_count}, 32'h0);
    #1 rst = 0;

    // Bubble counter saturation
    clear_id();
    flush = 1;
    for (int i = 0; i < 65534; i++) step();
    chk("sat_near", {16'b0, bubble_count}, 32'hFFFE);
    for (int i = 0; i < 3; i++) step();
    chk("sat_hold", {16'b0, bubble_count}, 32'hFFFF);
    flush = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
